uart_alu_frame_ctrl: RTL and testbench

- Parametrised successor to the fixed 8-bit UART↔ALU interface.
- Collects operand A, operand B and an opcode from the UART receive FIFO, drives a combinational ALU, and returns the result through the UART transmit FIFO.
- Operands are multi-word (NB_DATA wide, sent as NB_DATA/DBIT UART words, LSB word first).
- Adds an inter-word timeout with frame abort, tx back-pressure handling and status flags.

---
 rtl/uart_alu_frame_ctrl.sv | 131 +++++++++++++
 tb/tb_uart_alu_frame_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_alu_frame_ctrl.sv
// Frame controller: gathers A, B (NW words each, LSB word first) and an opcode from the rx FIFO, runs the ALU, returns NW result words.
// Frame = 2*NW+1 reads + 1 exec + NW writes; stalls on rx_empty / tx_full; inter-word timeout aborts a partial frame.
module uart_alu_frame_ctrl #(
    parameter int DBIT    = 8,
    parameter int NB_DATA = 16,
    parameter int NB_OP   = 6,
    parameter int TIMEOUT = 50000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [DBIT-1:0]    r_data,
    input  logic               rx_empty,
    output logic               rd_uart,
    output logic [DBIT-1:0]    w_data,
    input  logic               tx_full,
    output logic               wr_uart,
    output logic [NB_DATA-1:0] a,
    output logic [NB_DATA-1:0] b,
    output logic [NB_OP-1:0]   op,
    input  logic [NB_DATA-1:0] alu_result,
    output logic               busy,
    output logic               done,
    output logic               err_timeout
);
    localparam int NW = NB_DATA / DBIT;
    localparam int CW = $clog2(NW) + 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [2:0] {IDLE, GET_A, GET_B, GET_OP, EXEC, SEND} state_t;

    state_t             r_state;
    logic [CW-1:0]      r_cnt;
    logic [TW-1:0]      r_tcnt;
    logic [NB_DATA-1:0] r_a;
    logic [NB_DATA-1:0] r_b;
    logic [NB_OP-1:0]   r_op;
    logic [NB_DATA-1:0] r_result;

    logic w_get;
    logic w_partial;
    logic w_timeout;
    logic w_last;

    assign w_get     = (r_state == GET_A) || (r_state == GET_B) || (r_state == GET_OP);
    // Waiting for the very first word of a frame is not a partial frame.
    assign w_partial = ((r_state == GET_A) && (r_cnt != '0)) || (r_state == GET_B) || (r_state == GET_OP);
    assign w_timeout = (TIMEOUT != 0) && w_partial && rx_empty && (r_tcnt == TW'(TIMEOUT - 1));
    assign w_last    = (r_cnt == CW'(NW - 1));

    assign rd_uart     = w_get && !rx_empty;
    assign wr_uart     = (r_state == SEND) && !tx_full;
    assign done        = wr_uart && w_last;
    assign err_timeout = w_timeout;
    assign busy        = (r_state != IDLE);
    assign a           = r_a;
    assign b           = r_b;
    assign op          = r_op;

    always_comb begin
        w_data = '0;
        for (int i = 0; i < NW; i++) begin
            if (r_cnt == CW'(i)) w_data = r_result[i*DBIT +: DBIT];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_tcnt   <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_op     <= '0;
            r_result <= '0;
        end else begin
            if (rd_uart || !w_partial || w_timeout) r_tcnt <= '0;
            else if (TIMEOUT != 0)                  r_tcnt <= r_tcnt + TW'(1);

            case (r_state)
                IDLE: begin
                    r_cnt   <= '0;
                    r_state <= GET_A;
                end
                GET_A, GET_B: begin
                    if (w_timeout) begin
                        r_cnt   <= '0;
                        r_state <= GET_A;
                    end else if (!rx_empty) begin
                        for (int i = 0; i < NW; i++) begin
                            if (r_cnt == CW'(i)) begin
                                if (r_state == GET_A) r_a[i*DBIT +: DBIT] <= r_data;
                                else                  r_b[i*DBIT +: DBIT] <= r_data;
                            end
                        end
                        if (w_last) begin
                            r_cnt   <= '0;
                            r_state <= (r_state == GET_A) ? GET_B : GET_OP;
                        end else begin
                            r_cnt <= r_cnt + CW'(1);
                        end
                    end
                end
                GET_OP: begin
                    if (w_timeout) begin
                        r_cnt   <= '0;
                        r_state <= GET_A;
                    end else if (!rx_empty) begin
                        r_op    <= r_data[NB_OP-1:0];
                        r_state <= EXEC;
                    end
                end
                EXEC: begin
                    r_result <= alu_result;
                    r_cnt    <= '0;
                    r_state  <= SEND;
                end
                SEND: begin
                    if (!tx_full) begin
                        if (w_last) begin
                            r_cnt   <= '0;
                            r_state <= GET_A;
                        end else begin
                            r_cnt <= r_cnt + CW'(1);
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_alu_frame_ctrl.sv
// Scoreboard bench: a 16-bit/TIMEOUT=100 instance and a legacy 8-bit instance, each fed by a FIFO model.
module tb_uart_alu_frame_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    endtask

    // ---------------- 16-bit instance ----------------
    logic [7:0]  r_data1 = 8'h00;
    logic        rx_empty1 = 1'b1;
    logic        tx_full1 = 1'b0;
    logic        rd_uart1, wr_uart1, busy1, done1, err1;
    logic [7:0]  w_data1;
    logic [15:0] a1, b1, alu1;
    logic [5:0]  op1;

    function automatic logic [15:0] alu16(input logic [15:0] x, input logic [15:0] y, input logic [5:0] o);
        case (o)
            6'h20:   return x + y;
            6'h22:   return x - y;
            6'h24:   return x & y;
            default: return 16'h0;
        endcase
    endfunction
    assign alu1 = alu16(a1, b1, op1);

    uart_alu_frame_ctrl #(.DBIT(8), .NB_DATA(16), .NB_OP(6), .TIMEOUT(100)) dut1 (
        .clk(clk), .reset(reset), .r_data(r_data1), .rx_empty(rx_empty1), .rd_uart(rd_uart1),
        .w_data(w_data1), .tx_full(tx_full1), .wr_uart(wr_uart1), .a(a1), .b(b1), .op(op1),
        .alu_result(alu1), .busy(busy1), .done(done1), .err_timeout(err1)
    );

    logic [7:0] rxq1[$];
    logic [7:0] expq1[$];
    int push_cyc1[$];
    int cyc1 = 0, rd_cnt1 = 0, idle1 = 0, done_cnt1 = 0, err_cnt1 = 0, busy_lo1 = 0;
    int first_rd1 = 0, done_cyc1 = 0;
    bit mark1 = 0, tog1 = 0, gate1 = 0;

    // FIFO model + monitor: inputs change at negedge+1, outputs sampled at negedge+2.
    always begin
        @(negedge clk);
        #1;
        rx_empty1 = (rxq1.size() == 0) || (tog1 && gate1);
        r_data1   = (rxq1.size() != 0) ? rxq1[0] : 8'h00;
        if (tog1) gate1 = ~gate1;
        #1;
        cyc1++;
        if (rd_uart1) begin
            rxq1.delete(0);
            rd_cnt1++;
            idle1 = 0;
            if (mark1) begin first_rd1 = cyc1; mark1 = 0; end
        end else begin
            idle1++;
        end
        if (wr_uart1) begin
            push_cyc1.push_back(cyc1);
            chk("tx1_expected_word_pending", expq1.size() != 0, 1);
            if (expq1.size() != 0) chk("tx1_word", w_data1, expq1.pop_front());
        end
        if (done1) begin done_cnt1++; done_cyc1 = cyc1; end
        if (err1) begin
            err_cnt1++;
            chk("timeout_idle_cycles", idle1, 100);
        end
        if (!reset && !busy1) busy_lo1++;
    end

    task automatic drain1(input int maxc);
        int k = 0;
        while ((rxq1.size() != 0 || expq1.size() != 0) && k < maxc) begin
            @(negedge clk);
            k++;
        end
        repeat (2) @(negedge clk);
        chk("drain1_budget", rxq1.size() + expq1.size(), 0);
    endtask

    task automatic rx_wait1(input int maxc);
        int k = 0;
        while (rxq1.size() != 0 && k < maxc) begin
            @(negedge clk);
            k++;
        end
        chk("rx1_consumed", rxq1.size(), 0);
    endtask

    // ---------------- legacy 8-bit instance ----------------
    logic [7:0] r_data2 = 8'h00;
    logic       rx_empty2 = 1'b1;
    logic       tx_full2 = 1'b0;
    logic       rd_uart2, wr_uart2, busy2, done2, err2;
    logic [7:0] w_data2, a2, b2, alu2;
    logic [5:0] op2;

    assign alu2 = (op2 == 6'h20) ? a2 + b2 : (op2 == 6'h22) ? a2 - b2 : 8'h00;

    uart_alu_frame_ctrl #(.DBIT(8), .NB_DATA(8), .NB_OP(6), .TIMEOUT(50000)) dut2 (
        .clk(clk), .reset(reset), .r_data(r_data2), .rx_empty(rx_empty2), .rd_uart(rd_uart2),
        .w_data(w_data2), .tx_full(tx_full2), .wr_uart(wr_uart2), .a(a2), .b(b2), .op(op2),
        .alu_result(alu2), .busy(busy2), .done(done2), .err_timeout(err2)
    );

    logic [7:0] rxq2[$];
    logic [7:0] expq2[$];
    int done_cnt2 = 0;

    always begin
        @(negedge clk);
        #1;
        rx_empty2 = (rxq2.size() == 0);
        r_data2   = (rxq2.size() != 0) ? rxq2[0] : 8'h00;
        #1;
        if (rd_uart2) rxq2.delete(0);
        if (wr_uart2) begin
            chk("tx2_expected_word_pending", expq2.size() != 0, 1);
            if (expq2.size() != 0) chk("tx2_word", w_data2, expq2.pop_front());
        end
        if (done2) done_cnt2++;
    end

    // ---------------- stimulus ----------------
    initial begin
        int k;
        int rd_base;
        repeat (3) @(negedge clk);
        #2;
        chk("rst_a", a1, 0);
        chk("rst_b", b1, 0);
        chk("rst_op", op1, 0);
        chk("rst_busy", busy1, 0);
        chk("rst_rd_uart", rd_uart1, 0);
        chk("rst_wr_uart", wr_uart1, 0);
        chk("rst_done", done1, 0);
        chk("rst_err", err1, 0);
        chk("rst_w_data", w_data1, 0);
        @(negedge clk);
        reset = 1'b0;

        // Basic 16-bit ADD frame
        mark1 = 1;
        rxq1 = '{8'h01, 8'h00, 8'h03, 8'h00, 8'h20};
        expq1 = '{8'h04, 8'h00};
        drain1(200);
        chk("f1_a", a1, 16'h0001);
        chk("f1_b", b1, 16'h0003);
        chk("f1_op", op1, 6'h20);
        chk("f1_done_count", done_cnt1, 1);
        chk("f1_first_rd_to_done", done_cyc1 - first_rd1, 7);

        // Legacy 8-bit frames back to back
        rxq2 = '{8'h01, 8'h03, 8'h20, 8'h03, 8'h04, 8'h20};
        expq2 = '{8'h04, 8'h07};
        k = 0;
        while ((rxq2.size() != 0 || expq2.size() != 0) && k < 200) begin
            @(negedge clk);
            k++;
        end
        repeat (2) @(negedge clk);
        chk("legacy_drain", rxq2.size() + expq2.size(), 0);
        chk("legacy_a", a2, 8'h03);
        chk("legacy_b", b2, 8'h04);
        chk("legacy_done_count", done_cnt2, 2);

        // tx back-pressure: 0xBEEC + 0x0003 = 0xBEEF
        tx_full1 = 1'b1;
        push_cyc1.delete();
        rxq1 = '{8'hEC, 8'hBE, 8'h03, 8'h00, 8'h20};
        expq1 = '{8'hEF, 8'hBE};
        rx_wait1(100);
        repeat (20) @(negedge clk);
        chk("bp_no_push_in_stall", push_cyc1.size(), 0);
        tx_full1 = 1'b0;
        drain1(100);
        chk("bp_push_count", push_cyc1.size(), 2);
        if (push_cyc1.size() == 2) chk("bp_consecutive", push_cyc1[1] - push_cyc1[0], 1);

        // Inter-word timeout, then a clean SUB frame
        rxq1 = '{8'h12, 8'h34};
        repeat (110) @(negedge clk);
        chk("timeout_pulses", err_cnt1, 1);
        rxq1 = '{8'h05, 8'h00, 8'h02, 8'h00, 8'h22};
        expq1 = '{8'h03, 8'h00};
        drain1(200);
        chk("post_timeout_a", a1, 16'h0005);
        chk("post_timeout_op", op1, 6'h22);

        // Reset in the middle of GET_B
        rxq1 = '{8'h10, 8'h00, 8'h07};
        rx_wait1(50);
        chk("midrst_a_loaded", a1, 16'h0010);
        reset = 1'b1;
        @(negedge clk);
        #2;
        chk("midrst_a", a1, 0);
        chk("midrst_b", b1, 0);
        chk("midrst_op", op1, 0);
        chk("midrst_busy", busy1, 0);
        chk("midrst_rd", rd_uart1, 0);
        chk("midrst_wr", wr_uart1, 0);
        @(negedge clk);
        reset = 1'b0;
        rxq1 = '{8'h10, 8'h00, 8'h05, 8'h00, 8'h22};
        expq1 = '{8'h0B, 8'h00};
        drain1(200);
        chk("post_rst_b", b1, 16'h0005);

        // rx_empty toggling every other cycle
        rd_base = rd_cnt1;
        tog1 = 1;
        rxq1 = '{8'h34, 8'h12, 8'h11, 8'h11, 8'h20};
        expq1 = '{8'h45, 8'h23};
        drain1(300);
        tog1 = 0;
        chk("toggle_rd_count", rd_cnt1 - rd_base, 5);
        chk("toggle_a", a1, 16'h1234);

        chk("total_done_count", done_cnt1, 5);
        chk("total_timeouts", err_cnt1, 1);
        chk("busy_low_cycles", busy_lo1, 2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
